// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with memory-wait timeout.
// Latency 3-5 cycles per instruction plus memory wait cycles; requests hold steady until mem_ready.
module mips_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_step,
  output logic             jump,
  output logic             beq,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    FAULT    = 4'd15
  } state_t;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t           st;
  logic [TW-1:0]    tcnt;
  logic             is_store;
  logic [CNT_W-1:0] count;
  logic             step_c;
  logic             tmo;

  // funct only matters to the ALU decoder; every R-type funct is legal here.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign tmo         = (tcnt == TW'(MEM_TIMEOUT - 1));
  assign state       = st;
  assign instr_count = count;

  always_comb begin
    step_c = 1'b0;
    case (st)
      R_WB, MEM_WB, BRANCH, JUMP, I_WB: step_c = 1'b1;
      MEM_WR:                           step_c = mem_ready;
      default:                          step_c = 1'b0;
    endcase
  end

  // Wait-state exits (ready or timeout) both clear tcnt, so every wait state is entered with tcnt = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= FETCH;
      tcnt     <= '0;
      count    <= '0;
      is_store <= 1'b0;
    end else begin
      if (step_c) count <= count + CNT_W'(1);
      tcnt <= '0;
      case (st)
        FETCH, MEM_RD, MEM_WR: begin
          if (mem_ready) begin
            if (st == FETCH)       st <= DECODE;
            else if (st == MEM_RD) st <= MEM_WB;
            else                   st <= FETCH;
          end else if (tmo) begin
            st <= FAULT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DECODE: begin
          is_store <= (opcode == 6'h2B);
          case (opcode)
            6'h00:        st <= R_EXEC;
            6'h23, 6'h2B: st <= MEM_ADDR;
            6'h04:        st <= BRANCH;
            6'h02:        st <= JUMP;
            6'h08:        st <= I_EXEC;
            default:      st <= FAULT;
          endcase
        end
        MEM_ADDR: st <= is_store ? MEM_WR : MEM_RD;
        R_EXEC:   st <= R_WB;
        I_EXEC:   st <= I_WB;
        MEM_WB, R_WB, BRANCH, JUMP, I_WB: st <= FETCH;
        FAULT:    st <= FAULT;
        default:  st <= FAULT;
      endcase
    end
  end

  always_comb begin
    pc_step    = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_iord   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    fault      = 1'b0;
    if (!reset) begin
      case (st)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        MEM_ADDR: alu_src = 1'b1;
        MEM_RD: begin
          mem_read = 1'b1;
          mem_iord = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          pc_step    = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          mem_iord  = 1'b1;
          pc_step   = mem_ready;
        end
        R_EXEC: alu_op = 2'b10;
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          pc_step   = 1'b1;
        end
        BRANCH: begin
          alu_op  = 2'b01;
          pc_step = 1'b1;
          beq     = zero;
        end
        JUMP: begin
          pc_step = 1'b1;
          jump    = 1'b1;
        end
        I_EXEC: alu_src = 1'b1;
        I_WB: begin
          reg_write = 1'b1;
          pc_step   = 1'b1;
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control against a transaction-level expected-state sequence model.
module tb_mips_mc_control;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_REXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_IEXEC = 10, S_IWB = 11, S_FAULT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_step, jump, beq, ir_write, mem_read, mem_write, mem_iord;
  logic          reg_write, reg_dst, mem_to_reg, alu_src, fault;
  logic [1:0]    alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic [13:0]   outs;

  int n_checks = 0;
  int n_errors = 0;
  int cnt = 0;

  mips_mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_step(pc_step), .jump(jump), .beq(beq),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_iord(mem_iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .state(state), .fault(fault), .instr_count(instr_count)
  );

  assign outs = {pc_step, jump, beq, ir_write, mem_read, mem_write, mem_iord,
                 reg_write, reg_dst, mem_to_reg, alu_src, alu_op, fault};

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control outputs each state must show, straight from the state table.
  function automatic logic [13:0] exp_out(input int s, input bit r, input bit z);
    logic ps, jp, bq, ir, mr, mw, io, rw, rd, m2r, as, f;
    logic [1:0] ao;
    {ps, jp, bq, ir, mr, mw, io, rw, rd, m2r, as, f} = '0;
    ao = 2'b00;
    case (s)
      S_FETCH:  begin mr = 1; ir = r; end
      S_MADDR:  as = 1;
      S_MEMRD:  begin mr = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; ps = 1; end
      S_MEMWR:  begin mw = 1; io = 1; ps = r; end
      S_REXEC:  ao = 2'b10;
      S_RWB:    begin rw = 1; rd = 1; ps = 1; end
      S_BRANCH: begin ao = 2'b01; ps = 1; bq = z; end
      S_JUMP:   begin ps = 1; jp = 1; end
      S_IEXEC:  as = 1;
      S_IWB:    begin rw = 1; ps = 1; end
      S_FAULT:  f = 1;
      default:  ;
    endcase
    return {ps, jp, bq, ir, mr, mw, io, rw, rd, m2r, as, ao, f};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
  endfunction

  function automatic int base_lat(input logic [5:0] op);
    case (op)
      6'h23:        return 5;
      6'h04, 6'h02: return 3;
      default:      return 4;
    endcase
  endfunction

  // Assert reset for one edge, checking outputs gated low and the post-reset state.
  // Reset stays high on return; the next instruction releases it on its first cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
    opcode = 6'($urandom);
    #1;
    check("rst_outs_pre", 32'(outs), 32'h0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), S_FETCH);
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    cnt = 0;
  endtask

  task automatic idle_check(input string tag, input int exp);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check(tag, 32'(instr_count), 32'(exp));
  endtask

  // fd/md = cycles mem_ready stays low in fetch / data access; max_cyc truncates the run.
  task automatic do_instr(input logic [5:0] op, input bit z, input int fd, input int md,
                          input int max_cyc, input int hold, output bit faulted);
    int path[$];
    int sq[$];
    bit rq[$];
    int n, lat_got, irs, lat_exp;
    bit dead;
    logic [13:0] e;
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (op)
      6'h00: begin path.push_back(S_REXEC); path.push_back(S_RWB); end
      6'h23: begin path.push_back(S_MADDR); path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
      6'h2B: begin path.push_back(S_MADDR); path.push_back(S_MEMWR); end
      6'h04: path.push_back(S_BRANCH);
      6'h02: path.push_back(S_JUMP);
      6'h08: begin path.push_back(S_IEXEC); path.push_back(S_IWB); end
      default: path.push_back(S_FAULT);
    endcase
    dead = 0;
    foreach (path[k]) begin
      if (!dead) begin
        if (path[k] == S_FETCH || path[k] == S_MEMRD || path[k] == S_MEMWR) begin
          n = (path[k] == S_FETCH) ? fd : md;
          if (n >= TO) begin
            repeat (TO) begin sq.push_back(path[k]); rq.push_back(1'b0); end
            sq.push_back(S_FAULT); rq.push_back(1'($urandom_range(0, 1)));
            dead = 1;
          end else begin
            repeat (n) begin sq.push_back(path[k]); rq.push_back(1'b0); end
            sq.push_back(path[k]); rq.push_back(1'b1);
          end
        end else begin
          sq.push_back(path[k]); rq.push_back(1'($urandom_range(0, 1)));
          if (path[k] == S_FAULT) dead = 1;
        end
      end
    end
    if (dead) repeat (hold) begin sq.push_back(S_FAULT); rq.push_back(1'($urandom_range(0, 1))); end

    lat_got = 0;
    irs = 0;
    for (int i = 0; i < sq.size() && i < max_cyc; i++) begin
      @(negedge clk);
      reset = 1'b0;
      mem_ready = rq[i];
      zero = (sq[i] == S_BRANCH) ? z : 1'($urandom_range(0, 1));
      opcode = (sq[i] == S_FAULT) ? 6'($urandom) : op;
      funct = 6'($urandom);
      #1;
      e = exp_out(sq[i], rq[i], zero);
      check("state", 32'(state), 32'(sq[i]));
      check("outs", 32'(outs), 32'(e));
      check("count", 32'(instr_count), 32'(cnt % (1 << CW)));
      if (pc_step && lat_got == 0) lat_got = i + 1;
      if (ir_write) irs++;
      if (e[13]) cnt++;
    end
    faulted = dead;
    if (max_cyc >= sq.size()) begin
      if (dead) begin
        check("no_step", 32'(lat_got), 32'h0);
      end else begin
        lat_exp = base_lat(op) + fd + ((op == 6'h23 || op == 6'h2B) ? md : 0);
        check("latency", 32'(lat_got), 32'(lat_exp));
        check("ir_once", 32'(irs), 32'h1);
      end
    end
  endtask

  initial begin
    bit f;
    logic [5:0] op;
    int r;

    do_reset();
    // R-type with immediate memory, then lw with fetch/read waits
    do_instr(6'h00, 0, 0, 0, 1000, 0, f);
    idle_check("rtype_count", 1);
    do_reset();
    do_instr(6'h23, 0, 3, 2, 1000, 0, f);
    // beq taken then not taken
    do_instr(6'h04, 1, 0, 0, 1000, 0, f);
    do_instr(6'h04, 0, 0, 0, 1000, 0, f);
    // j then illegal opcode: sticky fault with the count held
    do_reset();
    do_instr(6'h02, 0, 0, 0, 1000, 0, f);
    do_instr(6'h3F, 0, 0, 0, 1000, 20, f);
    check("illegal_faulted", 32'(f), 32'h1);
    idle_check("fault_count", 1);
    do_reset();
    // sw with mem_ready never arriving
    do_instr(6'h2B, 0, 0, 100, 1000, 6, f);
    check("sw_timeout", 32'(f), 32'h1);
    do_reset();
    // reset in the middle of a read wait
    do_instr(6'h08, 0, 1, 0, 1000, 0, f);
    do_instr(6'h23, 0, 0, 100, 5, 0, f);
    do_reset();
    // 16 retirements wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 5);
      op = (r == 0) ? 6'h00 : (r == 1) ? 6'h23 : (r == 2) ? 6'h2B :
           (r == 3) ? 6'h04 : (r == 4) ? 6'h02 : 6'h08;
      do_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 1000, 0, f);
    end
    idle_check("wrap", 0);
    do_reset();
    // random mix, including timeouts and illegal opcodes
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 7: op = 6'h00;
        1, 8: op = 6'h23;
        2:    op = 6'h2B;
        3:    op = 6'h04;
        4:    op = 6'h02;
        5, 9: op = 6'h08;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      do_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5),
               1000, $urandom_range(1, 4), f);
      if (f) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
